// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture block: FSM encoding, legal
// output pixel widths and the frame-buffer depth calculation.
package cam_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        HOLD  = 2'd3
    } cap_state_t;

    localparam int unsigned DW_RGB332 = 8;
    localparam int unsigned DW_RGB444 = 12;
    localparam int unsigned DW_RGB565 = 16;

    function automatic bit dw_is_legal(input int unsigned dw);
        return (dw == DW_RGB332) || (dw == DW_RGB444) || (dw == DW_RGB565);
    endfunction

    function automatic bit decim_is_legal(input int unsigned d);
        return (d == 1) || (d == 2) || (d == 4);
    endfunction

    function automatic int unsigned frame_depth(input int unsigned w,
                                                input int unsigned h,
                                                input int unsigned d);
        return (w / d) * (h / d);
    endfunction

endpackage

// File: rtl/cam_capture_px_fmt_conv.sv
// Combinational RGB565 to RGB565/RGB444/RGB332 converter; keeps the MSBs
// of each colour channel.
module px_fmt_conv
    import cam_capture_pkg::*;
#(
    parameter int unsigned DW = 12
) (
    input  logic [15:0]   px_rgb565,
    output logic [DW-1:0] px_out
);

    generate
        if (DW == DW_RGB565) begin : g_565
            assign px_out = px_rgb565;
        end else if (DW == DW_RGB444) begin : g_444
            logic unused_bits;
            assign unused_bits = ^{px_rgb565[11], px_rgb565[6:5], px_rgb565[0]};
            assign px_out = {px_rgb565[15:12], px_rgb565[10:7], px_rgb565[4:1]};
        end else begin : g_332
            logic unused_bits;
            assign unused_bits = ^{px_rgb565[12:11], px_rgb565[7:5], px_rgb565[2:0]};
            assign px_out = {px_rgb565[15:13], px_rgb565[10:8], px_rgb565[4:3]};
        end
    endgenerate

endmodule

// File: rtl/cam_capture.sv
// Camera byte-stream capture: pairs bytes into RGB565 pixels, decimates,
// converts and writes them sequentially into a dual-port frame buffer.
module cam_capture
    import cam_capture_pkg::*;
#(
    parameter int unsigned AW    = 15,
    parameter int unsigned DW    = 12,
    parameter int unsigned IMG_W = 160,
    parameter int unsigned IMG_H = 120,
    parameter int unsigned DECIM = 1
) (
    input  logic          CAM_pclk,
    input  logic          rst,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [7:0]    CAM_px_data,
    input  logic          snap_mode,
    input  logic          arm,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          DP_RAM_regW,
    output logic          frame_done,
    output logic          frame_err
);

    localparam int unsigned DEPTH = frame_depth(IMG_W, IMG_H, DECIM);
    localparam int unsigned CW    = 16;
    localparam int unsigned ACW   = AW + 1;
    localparam logic [ACW-1:0] DEPTH_A = ACW'(DEPTH);
    localparam logic [CW-1:0]  W_C     = CW'(IMG_W);
    localparam logic [CW-1:0]  DMASK   = CW'(DECIM - 1);

    generate
        if (!dw_is_legal(DW)) begin : g_bad_dw
            $error("cam_capture: DW must be 8, 12 or 16");
        end
        if (!decim_is_legal(DECIM)) begin : g_bad_decim
            $error("cam_capture: DECIM must be 1, 2 or 4");
        end
        if (64'(DEPTH) > (64'd1 << AW)) begin : g_bad_depth
            $error("cam_capture: frame does not fit in 2**AW locations");
        end
    endgenerate

    cap_state_t     state, state_n;
    logic           vs_q, hr_q, arm_q;
    logic [7:0]     byte0_q;
    logic [CW-1:0]  x, y;
    logic [ACW-1:0] addr;
    logic [DW-1:0]  px_conv;

    logic vs_fall, vs_rise, hr_fall, start, close;
    logic px_done, half_drop, line_end, keep, wr, err_set;

    px_fmt_conv #(.DW(DW)) u_conv (
        .px_rgb565 ({byte0_q, CAM_px_data}),
        .px_out    (px_conv)
    );

    always_ff @(posedge CAM_pclk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = BYTE0;
            BYTE0: if (vs_rise)       state_n = snap_mode ? HOLD : IDLE;
                   else if (CAM_href) state_n = BYTE1;
            BYTE1: if (vs_rise) state_n = snap_mode ? HOLD : IDLE;
                   else         state_n = BYTE0;
            HOLD:  if (arm || arm_q) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Frame close takes priority over any pixel or line event in the same cycle.
    always_comb begin
        vs_fall   = vs_q & ~CAM_vsync;
        vs_rise   = ~vs_q & CAM_vsync;
        hr_fall   = hr_q & ~CAM_href;
        start     = (state == IDLE) && vs_fall && (!snap_mode || arm_q);
        close     = ((state == BYTE0) || (state == BYTE1)) && vs_rise;
        px_done   = (state == BYTE1) && CAM_href && !vs_rise;
        half_drop = (state == BYTE1) && !CAM_href && !vs_rise;
        line_end  = ((state == BYTE0) || (state == BYTE1)) && hr_fall && !vs_rise;
        keep      = ((x & DMASK) == '0) && ((y & DMASK) == '0);
        wr        = px_done && keep && (addr < DEPTH_A);
        err_set   = half_drop
                  || (px_done && keep && (addr >= DEPTH_A))
                  || (line_end && (x != W_C))
                  || (close && (addr != DEPTH_A));
    end

    always_ff @(posedge CAM_pclk or negedge rst) begin
        if (!rst) begin
            vs_q           <= 1'b0;
            hr_q           <= 1'b0;
            arm_q          <= 1'b0;
            byte0_q        <= '0;
            x              <= '0;
            y              <= '0;
            addr           <= '0;
            frame_err      <= 1'b0;
            frame_done     <= 1'b0;
            DP_RAM_regW    <= 1'b0;
            DP_RAM_addr_in <= '0;
            DP_RAM_data_in <= '0;
        end else begin
            vs_q  <= CAM_vsync;
            hr_q  <= CAM_href;
            arm_q <= start ? arm : (arm_q | arm);
            if ((state == BYTE0) && CAM_href && !vs_rise) byte0_q <= CAM_px_data;
            if (start) begin
                x    <= '0;
                y    <= '0;
                addr <= '0;
            end else begin
                if (line_end) begin
                    x <= '0;
                    y <= y + CW'(1);
                end else if (px_done) begin
                    x <= x + CW'(1);
                end
                if (wr) addr <= addr + ACW'(1);
            end
            if (start)        frame_err <= 1'b0;
            else if (err_set) frame_err <= 1'b1;
            frame_done  <= close;
            DP_RAM_regW <= wr;
            if (wr) begin
                DP_RAM_addr_in <= addr[AW-1:0];
                DP_RAM_data_in <= px_conv;
            end
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture: three instances (default, DECIM=2/DW=16,
// small 8x4 DW=8) share camera timing; a frame-level model predicts writes.
module tb_cam_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, vs, hr, snap, armp;
    logic [7:0] pa, pb, pc;

    logic [14:0] addr_a; logic [11:0] data_a; logic we_a, done_a, err_a;
    logic [14:0] addr_b; logic [15:0] data_b; logic we_b, done_b, err_b;
    logic [5:0]  addr_c; logic [7:0]  data_c; logic we_c, done_c, err_c;

    cam_capture u_dut (
        .CAM_pclk(clk), .rst(rst), .CAM_vsync(vs), .CAM_href(hr), .CAM_px_data(pa),
        .snap_mode(snap), .arm(armp), .DP_RAM_addr_in(addr_a), .DP_RAM_data_in(data_a),
        .DP_RAM_regW(we_a), .frame_done(done_a), .frame_err(err_a)
    );

    cam_capture #(.DW(16), .DECIM(2)) u_d2 (
        .CAM_pclk(clk), .rst(rst), .CAM_vsync(vs), .CAM_href(hr), .CAM_px_data(pb),
        .snap_mode(snap), .arm(armp), .DP_RAM_addr_in(addr_b), .DP_RAM_data_in(data_b),
        .DP_RAM_regW(we_b), .frame_done(done_b), .frame_err(err_b)
    );

    cam_capture #(.AW(6), .DW(8), .IMG_W(8), .IMG_H(4), .DECIM(1)) u_sm (
        .CAM_pclk(clk), .rst(rst), .CAM_vsync(vs), .CAM_href(hr), .CAM_px_data(pc),
        .snap_mode(snap), .arm(armp), .DP_RAM_addr_in(addr_c), .DP_RAM_data_in(data_c),
        .DP_RAM_regW(we_c), .frame_done(done_c), .frame_err(err_c)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] got_a[$], got_b[$], got_c[$], exp_q[$];
    int          done_cnt[3];
    int          exp_err;
    logic [31:0] first_got, first_exp;

    int          nlines;
    int          llen[128];
    int          brk[128];
    int          pmode;
    logic [15:0] cpx;
    logic [15:0] rnd_px[256];

    always @(negedge clk) begin
        if (we_a) got_a.push_back({16'(addr_a), 16'(data_a)});
        if (we_b) got_b.push_back({16'(addr_b), data_b});
        if (we_c) got_c.push_back({16'(addr_c), 8'h00, data_c});
        if (done_a) done_cnt[0]++;
        if (done_b) done_cnt[1]++;
        if (done_c) done_cnt[2]++;
    end

    function automatic int inst_w(input int i);     return (i == 2) ? 8 : 160; endfunction
    function automatic int inst_d(input int i);     return (i == 1) ? 2 : 1; endfunction
    function automatic int inst_dw(input int i);    return (i == 0) ? 12 : ((i == 1) ? 16 : 8); endfunction
    function automatic int inst_depth(input int i); return (i == 0) ? 19200 : ((i == 1) ? 4800 : 32); endfunction

    function automatic logic [15:0] pix(input int inst, input int x, input int y);
        if (pmode == 0) begin
            if (inst == 0) return 16'hF800;
            if (inst == 1) return 16'(y * 160 + x);
            return 16'(x * 37 + y);
        end
        if (pmode == 1) return rnd_px[(y * 16 + x) % 256];
        return cpx;
    endfunction

    function automatic logic [15:0] conv(input int dw, input logic [15:0] p);
        int r, g, b;
        r = int'(p) / 2048;
        g = (int'(p) / 32) % 64;
        b = int'(p) % 32;
        if (dw == 16) return p;
        if (dw == 12) return 16'((r / 2) * 256 + (g / 4) * 16 + b / 2);
        return 16'((r / 4) * 32 + (g / 8) * 4 + b / 8);
    endfunction

    // Expected writes and error flag for one frame as seen by instance inst.
    task automatic build_exp(input int inst);
        int cnt, n, d;
        bit bad;
        exp_q.delete();
        cnt = 0; bad = 0; d = inst_d(inst);
        for (int l = 0; l < nlines; l++) begin
            n = (brk[l] >= 0) ? brk[l] : llen[l];
            if (brk[l] >= 0 || n != inst_w(inst)) bad = 1;
            for (int x = 0; x < n; x++) begin
                if ((x % d) == 0 && (l % d) == 0) begin
                    if (cnt < inst_depth(inst))
                        exp_q.push_back({16'(cnt), conv(inst_dw(inst), pix(inst, x, l))});
                    cnt++;
                end
            end
        end
        if (cnt != inst_depth(inst)) bad = 1;
        exp_err = bad ? 1 : 0;
    endtask

    function automatic int got_size(input int inst);
        if (inst == 0) return got_a.size();
        if (inst == 1) return got_b.size();
        return got_c.size();
    endfunction

    function automatic logic [31:0] got_item(input int inst, input int i);
        if (inst == 0) return got_a[i];
        if (inst == 1) return got_b[i];
        return got_c[i];
    endfunction

    function automatic int mism(input int inst);
        int sz, n, bad;
        logic [31:0] g;
        sz = got_size(inst);
        n = (sz > exp_q.size()) ? sz : exp_q.size();
        bad = 0; first_got = '0; first_exp = '0;
        for (int i = 0; i < n; i++) begin
            if (i >= sz || i >= exp_q.size()) begin
                bad++;
            end else begin
                g = got_item(inst, i);
                if (g !== exp_q[i]) begin
                    if (bad == 0) begin first_got = g; first_exp = exp_q[i]; end
                    bad++;
                end
            end
        end
        return bad;
    endfunction

    task automatic drive(input logic v, input logic h, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c, input logic am);
        @(posedge clk);
        #1;
        vs = v; hr = h; pa = a; pb = b; pc = c; armp = am;
    endtask

    task automatic set_lines(input int n, input int len);
        nlines = n;
        for (int l = 0; l < 128; l++) begin llen[l] = len; brk[l] = -1; end
    endtask

    task automatic run_frame(input logic arm_at_fall);
        logic [15:0] p0, p1, p2;
        got_a.delete(); got_b.delete(); got_c.delete();
        done_cnt = '{0, 0, 0};
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, arm_at_fall);
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        for (int l = 0; l < nlines; l++) begin
            repeat ($urandom_range(5, 2)) drive(0, 0, 0, 0, 0, 0);
            for (int x = 0; x < llen[l]; x++) begin
                p0 = pix(0, x, l); p1 = pix(1, x, l); p2 = pix(2, x, l);
                drive(0, 1, p0[15:8], p1[15:8], p2[15:8], 0);
                if (brk[l] == x) break;
                drive(0, 1, p0[7:0], p1[7:0], p2[7:0], 0);
            end
        end
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        repeat (4) drive(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        checks++;
        if ({we_a, done_a, err_a, addr_a, data_a} !== '0) begin
            failures++; $display("FAIL reset_a: got %h expected 0", {we_a, done_a, err_a, addr_a, data_a});
        end
        checks++;
        if ({we_b, done_b, err_b, addr_b, data_b} !== '0) begin
            failures++; $display("FAIL reset_b: got %h expected 0", {we_b, done_b, err_b, addr_b, data_b});
        end
        checks++;
        if ({we_c, done_c, err_c, addr_c, data_c} !== '0) begin
            failures++; $display("FAIL reset_c: got %h expected 0", {we_c, done_c, err_c, addr_c, data_c});
        end
        rst = 1'b1;
        repeat (2) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_full_frame();
        int mm;
        logic [15:0] last;
        pmode = 0; snap = 0;
        set_lines(120, 160);
        run_frame(0);
        build_exp(0);
        mm = mism(0);
        checks++;
        if (got_a.size() !== 19200) begin failures++; $display("FAIL full_a_count: got %0d expected 19200", got_a.size()); end
        checks++;
        if (mm !== 0) begin failures++; $display("FAIL full_a_stream: mismatches=%0d expected 0 (first got %h exp %h)", mm, first_got, first_exp); end
        checks++;
        if (got_a.size() == 0 || got_a[0][15:0] !== 16'h0F00) begin failures++; $display("FAIL full_a_data0: expected 0f00, count %0d", got_a.size()); end
        last = (got_a.size() > 0) ? got_a[got_a.size() - 1][31:16] : 16'hFFFF;
        checks++;
        if (last !== 16'd19199) begin failures++; $display("FAIL full_a_last_addr: got %0d expected 19199", last); end
        checks++;
        if (done_cnt[0] !== 1) begin failures++; $display("FAIL full_a_done: got %0d expected 1", done_cnt[0]); end
        checks++;
        if (err_a !== 1'b0) begin failures++; $display("FAIL full_a_err: got %b expected 0", err_a); end

        build_exp(1);
        mm = mism(1);
        checks++;
        if (got_b.size() !== 4800) begin failures++; $display("FAIL decim_b_count: got %0d expected 4800", got_b.size()); end
        checks++;
        if (mm !== 0) begin failures++; $display("FAIL decim_b_stream: mismatches=%0d expected 0 (first got %h exp %h)", mm, first_got, first_exp); end
        last = (got_b.size() > 0) ? got_b[got_b.size() - 1][31:16] : 16'hFFFF;
        checks++;
        if (last !== 16'd4799) begin failures++; $display("FAIL decim_b_last_addr: got %0d expected 4799", last); end
        checks++;
        if (done_cnt[1] !== 1 || err_b !== 1'b0) begin failures++; $display("FAIL decim_b_close: done %0d err %b expected 1 0", done_cnt[1], err_b); end
    endtask

    task automatic test_dw8();
        int bad;
        logic [7:0] want [2];
        logic [15:0] src [2];
        src[0] = 16'hFFFF; want[0] = 8'hFF;
        src[1] = 16'h07E0; want[1] = 8'h1C;
        pmode = 2;
        for (int k = 0; k < 2; k++) begin
            cpx = src[k];
            set_lines(4, 8);
            run_frame(0);
            bad = 0;
            foreach (got_c[i]) if (got_c[i][7:0] !== want[k]) bad++;
            checks++;
            if (bad !== 0 || got_c.size() !== 32) begin
                failures++; $display("FAIL dw8_data_%0d: bad=%0d count=%0d expected 0 and 32 of %h", k, bad, got_c.size(), want[k]);
            end
            checks++;
            if (err_c !== 1'b0) begin failures++; $display("FAIL dw8_err_%0d: got %b expected 0", k, err_c); end
        end
    endtask

    task automatic test_half_pixel();
        int mm;
        pmode = 1;
        foreach (rnd_px[i]) rnd_px[i] = 16'($urandom);
        set_lines(4, 8);
        brk[0] = 5;
        run_frame(0);
        build_exp(2);
        mm = mism(2);
        checks++;
        if (err_c !== 1'b1) begin failures++; $display("FAIL half_err: got %b expected 1", err_c); end
        checks++;
        if (got_c.size() !== 29) begin failures++; $display("FAIL half_count: got %0d expected 29", got_c.size()); end
        checks++;
        if (mm !== 0) begin failures++; $display("FAIL half_stream: mismatches=%0d expected 0 (first got %h exp %h)", mm, first_got, first_exp); end
    endtask

    task automatic test_overflow();
        logic [15:0] last;
        pmode = 1;
        set_lines(5, 8);
        run_frame(0);
        last = (got_c.size() > 0) ? got_c[got_c.size() - 1][31:16] : 16'hFFFF;
        checks++;
        if (got_c.size() !== 32 || last !== 16'd31) begin
            failures++; $display("FAIL ovf_writes: count %0d last %0d expected 32 31", got_c.size(), last);
        end
        checks++;
        if (err_c !== 1'b1) begin failures++; $display("FAIL ovf_err: got %b expected 1", err_c); end
    endtask

    task automatic test_random();
        int mm;
        pmode = 1;
        for (int f = 0; f < 6; f++) begin
            foreach (rnd_px[i]) rnd_px[i] = 16'($urandom);
            set_lines(int'($urandom_range(5, 3)), 8);
            for (int l = 0; l < nlines; l++) begin
                if ($urandom_range(5, 0) == 0) llen[l] = int'($urandom_range(9, 7));
                if ($urandom_range(7, 0) == 0) brk[l] = int'($urandom_range(llen[l] - 1, 0));
            end
            run_frame(0);
            build_exp(2);
            mm = mism(2);
            checks++;
            if (mm !== 0) begin failures++; $display("FAIL rand_stream_%0d: mismatches=%0d expected 0 (first got %h exp %h)", f, mm, first_got, first_exp); end
            checks++;
            if (int'(err_c) !== exp_err) begin failures++; $display("FAIL rand_err_%0d: got %b expected %0d", f, err_c, exp_err); end
            checks++;
            if (done_cnt[2] !== 1) begin failures++; $display("FAIL rand_done_%0d: got %0d expected 1", f, done_cnt[2]); end
        end
    endtask

    task automatic test_snap();
        int want_n [5];
        want_n = '{32, 0, 0, 0, 32};
        pmode = 1;
        snap = 1;
        drive(1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0);
        for (int f = 0; f < 5; f++) begin
            set_lines(4, 8);
            run_frame(f == 3);
            checks++;
            if (got_c.size() !== want_n[f] || done_cnt[2] !== (want_n[f] != 0 ? 1 : 0)) begin
                failures++; $display("FAIL snap_frame_%0d: writes %0d done %0d expected %0d", f + 1, got_c.size(), done_cnt[2], want_n[f]);
            end
        end
        snap = 0;
    endtask

    task automatic test_reset_mid();
        int mm;
        drive(1, 0, 0, 0, 0, 1);
        repeat (2) drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        for (int x = 0; x < 100; x++) begin
            drive(0, 1, 8'hF8, 8'h12, 8'h00, 0);
            drive(0, 1, 8'h00, 8'h34, 8'h00, 0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (we_a !== 1'b1 || addr_a !== 15'd99) begin
            failures++; $display("FAIL rstmid_pre: we %b addr %0d expected 1 99", we_a, addr_a);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({we_a, done_a, err_a, addr_a, data_a} !== '0) begin
            failures++; $display("FAIL rstmid_async: got %h expected 0", {we_a, done_a, err_a, addr_a, data_a});
        end
        got_a.delete();
        done_cnt = '{0, 0, 0};
        drive(0, 1, 8'hF8, 8'h00, 8'h00, 0);
        rst = 1'b1;
        for (int x = 0; x < 160; x++) drive(0, 1, 8'hF8, 8'h00, 8'h00, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0);
        for (int x = 0; x < 320; x++) drive(0, 1, 8'h0F, 8'h00, 8'h00, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0);
        repeat (4) drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (got_a.size() !== 0 || done_cnt[0] !== 0) begin
            failures++; $display("FAIL rstmid_quiet: writes %0d done %0d expected 0 0", got_a.size(), done_cnt[0]);
        end
        pmode = 1;
        foreach (rnd_px[i]) rnd_px[i] = 16'($urandom);
        set_lines(4, 8);
        run_frame(0);
        build_exp(2);
        mm = mism(2);
        checks++;
        if (mm !== 0 || err_c !== 1'b0) begin
            failures++; $display("FAIL rstmid_resume: mismatches=%0d err %b expected 0 0", mm, err_c);
        end
    endtask

    initial begin
        rst = 1'b0; vs = 1'b0; hr = 1'b0; snap = 1'b0; armp = 1'b0;
        pa = '0; pb = '0; pc = '0; cpx = '0; pmode = 0;
        done_cnt = '{0, 0, 0};
        set_lines(4, 8);
        foreach (rnd_px[i]) rnd_px[i] = '0;
        test_reset();
        test_full_frame();
        test_dw8();
        test_half_pixel();
        test_overflow();
        test_random();
        test_snap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
